// File: rtl/gba_timer_array_if.sv
// Register bus between the IO register fabric and the timer array.
// The master drives strobes, address and write data; the timer array
// returns registered read data with a one-cycle valid.
interface gba_timer_array_if #(
  parameter int CNT_W = 16,
  parameter int ADR_W = 4
);
  logic             reg_wr;
  logic             reg_rd;
  logic [ADR_W-1:0] reg_adr;
  logic [CNT_W-1:0] reg_din;
  logic [CNT_W-1:0] reg_dout;
  logic             reg_rvalid;

  modport master (
    output reg_wr,
    output reg_rd,
    output reg_adr,
    output reg_din,
    input  reg_dout,
    input  reg_rvalid
  );

  modport slave (
    input  reg_wr,
    input  reg_rd,
    input  reg_adr,
    input  reg_din,
    output reg_dout,
    output reg_rvalid
  );
endinterface

// File: rtl/gba_timer_array.sv
// N-channel cascaded timer unit.
// Each channel: up-counter with reload, 1/64/256/1024 prescaler, count-up
// chaining from the previous channel's tick, IRQ pulse and one-shot mode.
// Register map: 2*ch = COUNT (read) / RELOAD (write), 2*ch+1 = CTRL.
// CTRL: [1:0] prescale, [2] count_up, [3] one_shot, [6] irq_en, [7] start.
module gba_timer_array #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int ADR_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gb_on,
  gba_timer_array_if.slave  bus,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] irq
);

  // CTRL bit positions and the mask of implemented bits (others read 0).
  localparam int         B_CUP   = 2;
  localparam int         B_OS    = 3;
  localparam int         B_IE    = 6;
  localparam int         B_START = 7;
  localparam logic [7:0] CTRL_MASK = 8'hCF;

  // Per-channel architectural state.
  logic [CNT_W-1:0] count_q  [NUM_CH];
  logic [CNT_W-1:0] reload_q [NUM_CH];
  logic [7:0]       ctrl_q   [NUM_CH];
  logic [9:0]       presc_q  [NUM_CH];

  // Registered outputs (one cycle after the event that caused them).
  logic [NUM_CH-1:0] tick_p1;
  logic [NUM_CH-1:0] irq_p1;
  logic [CNT_W-1:0]  rd_data_p1;
  logic              rd_vld_p1;

  // Decoded per-channel strobes and events for the current cycle.
  logic [NUM_CH-1:0] wr_reload;
  logic [NUM_CH-1:0] wr_ctrl;
  logic [NUM_CH-1:0] start_rise;
  logic [NUM_CH-1:0] run;
  logic [NUM_CH-1:0] inc_evt;
  logic [NUM_CH-1:0] ovf;
  logic [NUM_CH:0]   chain_in;
  logic [CNT_W-1:0]  rd_data;

  // Prescaler event: low k bits of the free-running prescaler all ones,
  // k = 0/6/8/10 for divide 1/64/256/1024 (k=0 fires every cycle).
  function automatic logic presc_hit(input logic [9:0] p, input logic [1:0] sel);
    logic hit;
    case (sel)
      2'd0:    hit = 1'b1;
      2'd1:    hit = &p[5:0];
      2'd2:    hit = &p[7:0];
      default: hit = &p[9:0];
    endcase
    return hit;
  endfunction

  // Next counter value on an increment: wrap to reload on overflow.
  function automatic logic [CNT_W-1:0] count_next(input logic [CNT_W-1:0] c,
                                                  input logic [CNT_W-1:0] rl);
    return (&c) ? rl : c + 1'b1;
  endfunction

  // Register address decode and per-channel increment/overflow detection.
  always_comb begin
    wr_reload  = '0;
    wr_ctrl    = '0;
    start_rise = '0;
    run        = '0;
    inc_evt    = '0;
    ovf        = '0;
    // chain_in[ch] is the registered tick of channel ch-1 (0 for channel 0).
    chain_in   = {tick_p1, 1'b0};
    for (int ch = 0; ch < NUM_CH; ch++) begin
      wr_reload[ch]  = bus.reg_wr && (bus.reg_adr == ADR_W'(2 * ch));
      wr_ctrl[ch]    = bus.reg_wr && (bus.reg_adr == ADR_W'(2 * ch + 1));
      start_rise[ch] = wr_ctrl[ch] && bus.reg_din[B_START] && !ctrl_q[ch][B_START];
      run[ch]        = ctrl_q[ch][B_START] && gb_on;
      if ((ch != 0) && ctrl_q[ch][B_CUP]) begin
        inc_evt[ch] = run[ch] && chain_in[ch];
      end else begin
        inc_evt[ch] = run[ch] && presc_hit(presc_q[ch], ctrl_q[ch][1:0]);
      end
      ovf[ch] = inc_evt[ch] && (&count_q[ch]);
    end
  end

  // Read mux: live COUNT on even addresses, CTRL on odd, 0 when unmapped.
  always_comb begin
    rd_data = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (bus.reg_adr == ADR_W'(2 * ch)) begin
        rd_data = count_q[ch];
      end
      if (bus.reg_adr == ADR_W'(2 * ch + 1)) begin
        rd_data = CNT_W'(ctrl_q[ch]);
      end
    end
  end

  // Channel state: prescalers, counters, reload and control registers.
  // Later assignments deliberately override earlier ones: a CTRL write
  // beats one-shot start clearing, and a start load beats an increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        count_q[ch]  <= '0;
        reload_q[ch] <= '0;
        ctrl_q[ch]   <= '0;
        presc_q[ch]  <= '0;
      end
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (run[ch]) begin
          presc_q[ch] <= presc_q[ch] + 10'd1;
        end
        if (inc_evt[ch]) begin
          count_q[ch] <= count_next(count_q[ch], reload_q[ch]);
        end
        if (ovf[ch] && ctrl_q[ch][B_OS]) begin
          ctrl_q[ch][B_START] <= 1'b0;
        end
        if (wr_ctrl[ch]) begin
          ctrl_q[ch] <= bus.reg_din[7:0] & CTRL_MASK;
        end
        if (start_rise[ch]) begin
          count_q[ch] <= reload_q[ch];
          presc_q[ch] <= '0;
        end
        // Overflow above already sampled the old reload value.
        if (wr_reload[ch]) begin
          reload_q[ch] <= bus.reg_din;
        end
      end
    end
  end

  // ---- stage p1: registered tick/irq pulses ----
  // Overflow implies gb_on, so pulses are naturally suppressed while frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_p1 <= '0;
      irq_p1  <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        tick_p1[ch] <= ovf[ch];
        irq_p1[ch]  <= ovf[ch] && ctrl_q[ch][B_IE];
      end
    end
  end

  // ---- stage p1: registered read data and valid ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_p1 <= '0;
      rd_vld_p1  <= 1'b0;
    end else begin
      rd_vld_p1  <= bus.reg_rd;
      rd_data_p1 <= bus.reg_rd ? rd_data : '0;
    end
  end

  assign tick           = tick_p1;
  assign irq            = irq_p1;
  assign bus.reg_dout   = rd_data_p1;
  assign bus.reg_rvalid = rd_vld_p1;

endmodule

// File: tb/tb_gba_timer_array.sv
// Self-checking bench for gba_timer_array: directed scenarios plus a
// randomized phase, all compared cycle by cycle with a behavioural model.
module tb_gba_timer_array;
  localparam int NCH  = 4;
  localparam int CW   = 16;
  localparam int AW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           gb_on;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] irq;

  gba_timer_array_if #(.CNT_W(CW), .ADR_W(AW)) bus ();

  gba_timer_array #(.NUM_CH(NCH), .CNT_W(CW), .ADR_W(AW)) dut (
    .clk   (clk),
    .reset (rst),
    .gb_on (gb_on),
    .bus   (bus),
    .tick  (tick),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: plain integers and flags per channel.
  int       m_cnt [NCH];
  int       m_rel [NCH];
  int       m_pc  [NCH];   // cycles counted while running, modulo 1024
  int       m_psel[NCH];
  bit       m_cup [NCH];
  bit       m_os  [NCH];
  bit       m_ie  [NCH];
  bit       m_st  [NCH];
  bit [NCH-1:0] m_tick;
  bit [NCH-1:0] m_irq;
  int       m_dout;
  bit       m_rv;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_read(input int a);
    int ch;
    if (a >= 2 * NCH) return 0;
    ch = a / 2;
    if (a % 2 == 0) return m_cnt[ch];
    return (int'(m_st[ch]) << 7) | (int'(m_ie[ch]) << 6) | (int'(m_os[ch]) << 3)
         | (int'(m_cup[ch]) << 2) | m_psel[ch];
  endfunction

  // One clock of the timer rules, from the inputs present at the edge.
  task automatic model_step(input bit w, input bit r, input int a, input int d);
    bit [NCH-1:0] prev;
    bit [NCH-1:0] nt;
    bit [NCH-1:0] ni;
    int div;
    bit ev, ov, old_st;
    if (rst) begin
      for (int ch = 0; ch < NCH; ch++) begin
        m_cnt[ch] = 0; m_rel[ch] = 0; m_pc[ch] = 0; m_psel[ch] = 0;
        m_cup[ch] = 0; m_os[ch] = 0; m_ie[ch] = 0; m_st[ch] = 0;
      end
      m_tick = '0; m_irq = '0; m_dout = 0; m_rv = 0;
      return;
    end
    prev   = m_tick;
    m_rv   = r;
    m_dout = r ? m_read(a) : 0;
    nt = '0;
    ni = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      div    = (m_psel[ch] == 0) ? 1 : (1 << (4 + 2 * m_psel[ch]));
      old_st = m_st[ch];
      ev     = 0;
      if (m_st[ch] && gb_on) begin
        if (ch > 0 && m_cup[ch]) ev = prev[ch-1];
        else                     ev = ((m_pc[ch] % div) == div - 1);
        m_pc[ch] = (m_pc[ch] + 1) % 1024;
      end
      ov     = ev && (m_cnt[ch] == CMAX);
      nt[ch] = ov;
      ni[ch] = ov && m_ie[ch];
      if (ev) m_cnt[ch] = ov ? m_rel[ch] : m_cnt[ch] + 1;
      if (ov && m_os[ch]) m_st[ch] = 0;
      if (w && a == 2 * ch + 1) begin
        if (d[7] && !old_st) begin
          m_cnt[ch] = m_rel[ch];
          m_pc[ch]  = 0;
        end
        m_psel[ch] = d & 3;
        m_cup[ch]  = d[2];
        m_os[ch]   = d[3];
        m_ie[ch]   = d[6];
        m_st[ch]   = d[7];
      end
      if (w && a == 2 * ch) m_rel[ch] = d & CMAX;
    end
    m_tick = nt;
    m_irq  = ni;
  endtask

  // Drive one cycle, advance the model at the edge, compare on the falling edge.
  task automatic cyc(input bit w, input bit r, input int a, input int d);
    bus.reg_wr  = w;
    bus.reg_rd  = r;
    bus.reg_adr = a[AW-1:0];
    bus.reg_din = d[CW-1:0];
    @(posedge clk);
    model_step(w, r, a & ((1 << AW) - 1), d & CMAX);
    @(negedge clk);
    chk("tick",   int'(tick), int'(m_tick));
    chk("irq",    int'(irq), int'(m_irq));
    chk("rvalid", int'(bus.reg_rvalid), int'(m_rv));
    chk("dout",   int'(bus.reg_dout), m_dout);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic wr_reg(input int a, input int d);
    cyc(1, 0, a, d);
  endtask

  task automatic rd_reg(input int a, output int v);
    cyc(0, 1, a, 0);
    v = int'(bus.reg_dout);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  // Cycles until tick[ch] (or irq[ch]) is seen; bounded so a dead channel
  // shows up as a wrong count instead of a hang.
  task automatic wait_evt(input int ch, input bit use_irq, output int n);
    n = 0;
    do begin
      cyc(0, 0, 0, 0);
      n++;
    end while (!(use_irq ? irq[ch] : tick[ch]) && n < 3000);
  endtask

  initial begin
    int v, n, cnt;
    bit w, r;
    int a, d, ra;
    rst = 1'b1;
    gb_on = 1'b1;
    bus.reg_wr = 1'b0; bus.reg_rd = 1'b0; bus.reg_adr = '0; bus.reg_din = '0;

    // Reset state
    do_reset();
    chk("rst_tick", int'(tick), 0);
    chk("rst_irq",  int'(irq), 0);
    rd_reg(0, v); chk("rst_count0", v, 0);
    rd_reg(1, v); chk("rst_ctrl0",  v, 0);
    cyc(1, 0, 9, 'hFFFF);
    rd_reg(9, v); chk("unmapped_rd", v, 0);

    // ch0 divide-by-1, reload 0xFFFC: tick every 4 cycles
    wr_reg(0, 'hFFFC);
    wr_reg(1, 'h80);
    wait_evt(0, 0, n); chk("t0_first", n, 4);
    wait_evt(0, 0, n); chk("t0_period", n, 4);

    // ch0 divide-by-64 with a 10-cycle gb_on pause mid-period
    do_reset();
    wr_reg(0, 'hFFFF);
    wr_reg(1, 'h81);
    wait_evt(0, 0, n); chk("p64_first", n, 64);
    idle(20);
    gb_on = 1'b0;
    idle(10);
    gb_on = 1'b1;
    wait_evt(0, 0, n); chk("p64_paused", n + 30, 74);
    wait_evt(0, 0, n); chk("p64_period", n, 64);

    // ch1 count-up from ch0
    do_reset();
    wr_reg(2, 'hFFFE);
    wr_reg(3, 'h84);
    wr_reg(0, 'hFFFF);
    wr_reg(1, 'h80);
    wait_evt(1, 0, n); chk("cup_first", n, 3);
    chk("cup_prev_tick0", int'(tick[0]), 1);
    wait_evt(1, 0, n); chk("cup_period", n, 2);

    // ch2 one-shot with irq
    do_reset();
    wr_reg(4, 'hFFF0);
    wr_reg(5, 'hC8);
    wait_evt(2, 1, n); chk("os_first", n, 16);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 0, 0);
      cnt += int'(irq[2]);
    end
    chk("os_no_more_irq", cnt, 0);
    rd_reg(5, v); chk("os_ctrl", v, 'h48);
    rd_reg(4, v); chk("os_count", v, 'hFFF0);

    // RELOAD write landing on the overflow cycle
    do_reset();
    wr_reg(0, 'hFFFC);
    wr_reg(1, 'h80);
    idle(3);
    wr_reg(0, 'h1234);
    rd_reg(0, v); chk("rl_old", v, 'hFFFC);
    idle(3);
    rd_reg(0, v); chk("rl_new", v, 'h1234);

    // Reset while all channels run
    for (int ch = 0; ch < NCH; ch++) begin
      wr_reg(2 * ch, 'hFFFE);
      wr_reg(2 * ch + 1, 'hC0);
    end
    idle(7);
    rst = 1'b1;
    idle(1);
    chk("mid_rst_tick", int'(tick), 0);
    chk("mid_rst_irq",  int'(irq), 0);
    rst = 1'b0;
    idle(1);
    chk("post_rst_tick", int'(tick), 0);
    rd_reg(0, v); chk("post_rst_count", v, 0);
    rd_reg(1, v); chk("post_rst_ctrl",  v, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 499) == 0);
      gb_on = ($urandom_range(0, 9) != 0);
      w = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 2) == 0);
      a = $urandom_range(0, (1 << AW) - 1);
      if (w && a % 2 == 1) begin
        d = $urandom_range(0, CMAX);
        if ($urandom_range(0, 3) != 0) d = d & ~3;
      end else if ($urandom_range(0, 3) != 0) begin
        d = 'hFFF0 | $urandom_range(0, 15);
      end else begin
        d = $urandom_range(0, CMAX);
      end
      ra = $urandom_range(0, (1 << AW) - 1);
      cyc(w, r, (w ? a : ra), d);
    end
    rst = 1'b0;
    gb_on = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
